pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage register for the 5-stage MIPS pipeline; replaces the fixed
//   per-stage registers (D/E, E/M, M/W) with one block instanced per boundary.
//   Carries PC/Instr/operands/ext-imm/A3 plus a valid bit and Tnew. Tnew comes from the
//   decoder, so the register holds no opcode table. Supports hold or bubble on stall,
//   flush, and saturating Tnew aging. Exports a forwarding-ready flag to hazard control.
// PARAMETERS
//   DATA_W     32           width of PC, Instr, V1, V2, E32
//   A3_W       5            destination register index width
//   TNEW_W     2            Tnew width
//   TNEW_DEC   0            0: Tnew loaded as-is (D/E); 1: loaded as sat(in_tnew-1) (E/M, M/W)
//   STALL_MODE 0            0: hold contents on stall (D/E at E-busy); 1: insert bubble on stall
//   RESET_PC   32'h00003000 PC value after reset/flush
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   stall      in   1        stall request from hazard unit
//   flush      in   1        synchronous clear (branch/jump kill)
//   in_valid   in   1        upstream slot holds a real instruction
//   in_pc      in   DATA_W   upstream PC
//   in_instr   in   DATA_W   upstream instruction word
//   in_v1      in   DATA_W   operand 1 (rs value, already forwarded)
//   in_v2      in   DATA_W   operand 2 (rt value, already forwarded)
//   in_e32     in   DATA_W   extended immediate / ALU result, per stage
//   in_a3      in   A3_W     destination register (0 = no write)
//   in_tnew    in   TNEW_W   Tnew of upstream instruction, relative to upstream stage
//   out_valid  out  1        registered valid
//   out_pc/out_instr/out_v1/out_v2/out_e32  out  DATA_W  registered payload
//   out_a3     out  A3_W     registered destination (forced 0 when out_valid=0)
//   out_tnew   out  TNEW_W   registered Tnew
//   fwd_ready  out  1        out_valid && out_a3!=0 && out_tnew==0 (combinational from regs)
// BEHAVIOUR
//   - Reset (reset=0, async): out_pc=RESET_PC; out_valid, out_instr, out_v1, out_v2,
//     out_e32, out_a3 and out_tnew all 0; fwd_ready=0. Release is sampled at the next edge.
//   - Priority at each rising edge: flush > stall > load.
//   - flush=1: same values as reset, including out_pc=RESET_PC, regardless of stall.
//   - stall=1, STALL_MODE=0: all outputs hold. Tnew does not age; the slot does not advance.
//   - stall=1, STALL_MODE=1: bubble. out_valid, out_instr, v1, v2, e32, a3 and tnew are 0;
//     out_pc loads in_pc so PC stays traceable.
//   - Load: all payload fields take the in_* values; out_valid=in_valid.
//     out_a3 = in_valid ? in_a3 : 0.
//     out_tnew = TNEW_DEC ? (in_tnew==0 ? 0 : in_tnew-1) : in_tnew. Zeroed if in_valid=0.
//   - Latency: 1 cycle from input to output; no combinational path from in_* to out_*.
//   - Boundary cases:
//     in_tnew=0 with TNEW_DEC=1 saturates at 0 and never wraps.
//     Max in_tnew (2'b11) with TNEW_DEC=1 loads 2'b10.
//     Reset asserted mid-stall clears immediately; there is no pending-state memory.
//     flush and stall in the same cycle behave as flush.
//     fwd_ready is never 1 for out_a3=0 ($0 is never a forwarding source).
// STRUCTURE
//   - Shared constants header (constants.v) gains INITIAL_ADDRESS (the RESET_PC default)
//     and TNEW_W. No typedefs are needed.
//   - One sub-module, tnew_sat_dec (TNEW_W param): combinational saturating decrement,
//     instanced when TNEW_DEC=1.
//   - Payload is one packed register; the valid bit and Tnew are kept in separate
//     registers for clarity.
// TESTING
//   1. Assert reset=0 mid-cycle with out_pc=0x3008 -> out_pc=0x3000 and all other outputs
//      0 immediately, before the next edge.
//   2. TNEW_DEC=0, load in_tnew=2, in_a3=5, in_valid=1 -> next cycle out_tnew=2, out_a3=5,
//      fwd_ready=0.
//   3. TNEW_DEC=1 chain: load in_tnew=2, then in_tnew=1, then in_tnew=0 -> out_tnew is
//      1, 0, 0 (saturates). With in_tnew=1 and a3=5, fwd_ready goes to 1 on that load.
//   4. STALL_MODE=0: load PC 0x3004, then stall=1 for 3 cycles while inputs change
//      -> out_pc stays 0x3004 and every field holds.
//   5. STALL_MODE=1: stall=1 with in_pc=0x300c -> out_valid=0, out_instr=0, out_a3=0,
//      out_pc=0x300c.
//   6. flush=1 and stall=1 together with in_pc=0x3010 -> out_pc=0x3000 and all other
//      outputs 0. Also: load in_valid=0 with in_a3=7 -> out_a3=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline registers.
// Holds reset address and default field widths.
package pipe_stage_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int A3_W_DEF   = 5;
  localparam int TNEW_W_DEF = 2;

  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle between an upstream stage, the stage register and
// the downstream stage / hazard unit.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int A3_W   = A3_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
);

  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_v1;
  logic [DATA_W-1:0] in_v2;
  logic [DATA_W-1:0] in_e32;
  logic [A3_W-1:0]   in_a3;
  logic [TNEW_W-1:0] in_tnew;

  logic              out_valid;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_v1;
  logic [DATA_W-1:0] out_v2;
  logic [DATA_W-1:0] out_e32;
  logic [A3_W-1:0]   out_a3;
  logic [TNEW_W-1:0] out_tnew;
  logic              fwd_ready;

  modport master (
    output stall, flush, in_valid, in_pc, in_instr,
    output in_v1, in_v2, in_e32, in_a3, in_tnew,
    input  out_valid, out_pc, out_instr, out_v1,
    input  out_v2, out_e32, out_a3, out_tnew, fwd_ready
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_instr,
    input  in_v1, in_v2, in_e32, in_a3, in_tnew,
    output out_valid, out_pc, out_instr, out_v1,
    output out_v2, out_e32, out_a3, out_tnew, fwd_ready
  );

endinterface

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Saturating Tnew decrement: an instruction one stage older
// needs one cycle less, but never goes below zero.
module tnew_sat_dec #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_tnew,
  output logic [W-1:0] o_tnew
);

  assign o_tnew = (i_tnew == '0) ? '0 : i_tnew - W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register (D/E, E/M, M/W) with
// hold/bubble stall, flush and Tnew aging.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int              DATA_W     = DATA_W_DEF,
  parameter int              A3_W       = A3_W_DEF,
  parameter int              TNEW_W     = TNEW_W_DEF,
  parameter int              TNEW_DEC   = 0,
  parameter int              STALL_MODE = 0,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(INITIAL_ADDRESS)
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  localparam int PAY_W  = 5 * DATA_W + A3_W;
  localparam int ZERO_W = 4 * DATA_W + A3_W;
  localparam int O_E32  = A3_W;
  localparam int O_V2   = A3_W + DATA_W;
  localparam int O_V1   = A3_W + 2 * DATA_W;
  localparam int O_INS  = A3_W + 3 * DATA_W;
  localparam int O_PC   = A3_W + 4 * DATA_W;

  logic [PAY_W-1:0]  r_pay;
  logic              r_valid;
  logic [TNEW_W-1:0] r_tnew;
  logic [TNEW_W-1:0] w_tnew_ld;
  logic [A3_W-1:0]   w_a3_ld;

  generate
    if (TNEW_DEC != 0) begin : g_dec
      tnew_sat_dec #(.W(TNEW_W)) u_dec (
        .i_tnew (bus.in_tnew),
        .o_tnew (w_tnew_ld)
      );
    end else begin : g_pass
      assign w_tnew_ld = bus.in_tnew;
    end
  endgenerate

  // An empty slot must never look like a register writer.
  assign w_a3_ld = bus.in_valid ? bus.in_a3 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pay   <= {RESET_PC, {ZERO_W{1'b0}}};
      r_valid <= 1'b0;
      r_tnew  <= '0;
    end else if (bus.flush) begin
      r_pay   <= {RESET_PC, {ZERO_W{1'b0}}};
      r_valid <= 1'b0;
      r_tnew  <= '0;
    end else if (bus.stall) begin
      if (STALL_MODE != 0) begin
        r_pay   <= {bus.in_pc, {ZERO_W{1'b0}}};
        r_valid <= 1'b0;
        r_tnew  <= '0;
      end
    end else begin
      r_pay   <= {bus.in_pc, bus.in_instr, bus.in_v1,
                  bus.in_v2, bus.in_e32, w_a3_ld};
      r_valid <= bus.in_valid;
      r_tnew  <= bus.in_valid ? w_tnew_ld : '0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pay[O_PC  +: DATA_W];
  assign bus.out_instr = r_pay[O_INS +: DATA_W];
  assign bus.out_v1    = r_pay[O_V1  +: DATA_W];
  assign bus.out_v2    = r_pay[O_V2  +: DATA_W];
  assign bus.out_e32   = r_pay[O_E32 +: DATA_W];
  assign bus.out_a3    = r_pay[A3_W-1:0];
  assign bus.out_tnew  = r_tnew;

  assign bus.fwd_ready = r_valid
                       && (bus.out_a3 != '0)
                       && (r_tnew == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a hold/no-decrement instance (A)
// and a bubble/decrement instance (B) driven side by side.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] e32;
    logic [4:0]  a3;
    logic [1:0]  tnew;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] e32;
    logic [4:0]  a3;
    logic [1:0]  tnew;
  } st_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic [40:0] ea;
    logic [40:0] eb;
  } vec_t;

  logic clk;
  logic reset;
  in_t  cur;
  int   n_cmp;
  int   n_bad;

  pipe_stage_reg_if #(.DATA_W(32), .A3_W(5), .TNEW_W(2)) if_a ();
  pipe_stage_reg_if #(.DATA_W(32), .A3_W(5), .TNEW_W(2)) if_b ();

  pipe_stage_reg #(
    .DATA_W(32), .A3_W(5), .TNEW_W(2),
    .TNEW_DEC(0), .STALL_MODE(0), .RESET_PC(32'h3000)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  pipe_stage_reg #(
    .DATA_W(32), .A3_W(5), .TNEW_W(2),
    .TNEW_DEC(1), .STALL_MODE(1), .RESET_PC(32'h3000)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  assign if_a.stall    = cur.stall;
  assign if_a.flush    = cur.flush;
  assign if_a.in_valid = cur.valid;
  assign if_a.in_pc    = cur.pc;
  assign if_a.in_instr = cur.instr;
  assign if_a.in_v1    = cur.v1;
  assign if_a.in_v2    = cur.v2;
  assign if_a.in_e32   = cur.e32;
  assign if_a.in_a3    = cur.a3;
  assign if_a.in_tnew  = cur.tnew;
  assign if_b.stall    = cur.stall;
  assign if_b.flush    = cur.flush;
  assign if_b.in_valid = cur.valid;
  assign if_b.in_pc    = cur.pc;
  assign if_b.in_instr = cur.instr;
  assign if_b.in_v1    = cur.v1;
  assign if_b.in_v2    = cur.v2;
  assign if_b.in_e32   = cur.e32;
  assign if_b.in_a3    = cur.a3;
  assign if_b.in_tnew  = cur.tnew;

  st_t act_a;
  st_t act_b;

  always_comb begin
    act_a = {if_a.out_valid, if_a.out_pc, if_a.out_instr,
             if_a.out_v1, if_a.out_v2, if_a.out_e32,
             if_a.out_a3, if_a.out_tnew};
    act_b = {if_b.out_valid, if_b.out_pc, if_b.out_instr,
             if_b.out_v1, if_b.out_v2, if_b.out_e32,
             if_b.out_a3, if_b.out_tnew};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic st_t rst_st();
    st_t s;
    s    = '0;
    s.pc = 32'h3000;
    return s;
  endfunction

  // Reference: next slot contents from the stage rules.
  function automatic st_t step(st_t s, in_t i, bit dec, bit bub);
    st_t n;
    int  t;
    n = s;
    if (i.flush) begin
      n = rst_st();
    end else if (i.stall) begin
      if (bub) begin
        n    = '0;
        n.pc = i.pc;
      end
    end else begin
      t = int'(i.tnew);
      if (dec) t = (t > 0) ? t - 1 : 0;
      if (!i.valid) t = 0;
      n.valid = i.valid;
      n.pc    = i.pc;
      n.instr = i.instr;
      n.v1    = i.v1;
      n.v2    = i.v2;
      n.e32   = i.e32;
      n.a3    = i.valid ? i.a3 : 5'd0;
      n.tnew  = 2'(t);
    end
    return n;
  endfunction

  function automatic logic fwd_of(st_t s);
    return s.valid && (s.a3 != 0) && (s.tnew == 0);
  endfunction

  function automatic logic [40:0] e(logic v, logic [31:0] pc,
                                    logic [4:0] a3, logic [1:0] tn,
                                    logic f);
    return {v, pc, a3, tn, f};
  endfunction

  task automatic chk(string nm, logic [199:0] got, logic [199:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_both(string nm, st_t ma, st_t mb);
    chk({nm, "/A"}, 200'(act_a), 200'(ma));
    chk({nm, "/B"}, 200'(act_b), 200'(mb));
    chk({nm, "/A.fwd"}, 200'(if_a.fwd_ready), 200'(fwd_of(ma)));
    chk({nm, "/B.fwd"}, 200'(if_b.fwd_ready), 200'(fwd_of(mb)));
  endtask

  vec_t vt[11];
  st_t  ma;
  st_t  mb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cur   = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_both("reset", rst_st(), rst_st());
    reset = 1'b1;

    vt[0]  = '{1'b0, 1'b0, 1'b1, 32'h3004, 5'd5, 2'd2,
               e(1'b1, 32'h3004, 5'd5, 2'd2, 1'b0),
               e(1'b1, 32'h3004, 5'd5, 2'd1, 1'b0)};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 32'h3008, 5'd5, 2'd1,
               e(1'b1, 32'h3008, 5'd5, 2'd1, 1'b0),
               e(1'b1, 32'h3008, 5'd5, 2'd0, 1'b1)};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 32'h300c, 5'd5, 2'd0,
               e(1'b1, 32'h300c, 5'd5, 2'd0, 1'b1),
               e(1'b1, 32'h300c, 5'd5, 2'd0, 1'b1)};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h3010, 5'd6, 2'd3,
               e(1'b1, 32'h3010, 5'd6, 2'd3, 1'b0),
               e(1'b1, 32'h3010, 5'd6, 2'd2, 1'b0)};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h300c, 5'd7, 2'd0,
               e(1'b1, 32'h3010, 5'd6, 2'd3, 1'b0),
               e(1'b0, 32'h300c, 5'd0, 2'd0, 1'b0)};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h3018, 5'd7, 2'd1,
               e(1'b1, 32'h3010, 5'd6, 2'd3, 1'b0),
               e(1'b0, 32'h3018, 5'd0, 2'd0, 1'b0)};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h301c, 5'd3, 2'd2,
               e(1'b1, 32'h3010, 5'd6, 2'd3, 1'b0),
               e(1'b0, 32'h301c, 5'd0, 2'd0, 1'b0)};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h3010, 5'd5, 2'd0,
               e(1'b0, 32'h3000, 5'd0, 2'd0, 1'b0),
               e(1'b0, 32'h3000, 5'd0, 2'd0, 1'b0)};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h3024, 5'd7, 2'd2,
               e(1'b0, 32'h3024, 5'd0, 2'd0, 1'b0),
               e(1'b0, 32'h3024, 5'd0, 2'd0, 1'b0)};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h3028, 5'd0, 2'd0,
               e(1'b1, 32'h3028, 5'd0, 2'd0, 1'b0),
               e(1'b1, 32'h3028, 5'd0, 2'd0, 1'b0)};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h302c, 5'd5, 2'd0,
               e(1'b0, 32'h3000, 5'd0, 2'd0, 1'b0),
               e(1'b0, 32'h3000, 5'd0, 2'd0, 1'b0)};

    foreach (vt[k]) begin
      cur.stall = vt[k].stall;
      cur.flush = vt[k].flush;
      cur.valid = vt[k].valid;
      cur.pc    = vt[k].pc;
      cur.instr = vt[k].pc ^ 32'h0bad_0000;
      cur.v1    = vt[k].pc + 32'd1;
      cur.v2    = vt[k].pc + 32'd2;
      cur.e32   = vt[k].pc + 32'd3;
      cur.a3    = vt[k].a3;
      cur.tnew  = vt[k].tnew;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d/A", k),
          200'({if_a.out_valid, if_a.out_pc, if_a.out_a3,
                if_a.out_tnew, if_a.fwd_ready}),
          200'(vt[k].ea));
      chk($sformatf("vec%0d/B", k),
          200'({if_b.out_valid, if_b.out_pc, if_b.out_a3,
                if_b.out_tnew, if_b.fwd_ready}),
          200'(vt[k].eb));
    end

    // Async reset in the middle of a stall, before any edge.
    cur       = '0;
    cur.valid = 1'b1;
    cur.pc    = 32'h3008;
    cur.a3    = 5'd5;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_pc", 200'(if_a.out_pc), 200'(32'h3008));
    cur.stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_both("mid_rst", rst_st(), rst_st());
    @(negedge clk);
    cur   = '0;
    reset = 1'b1;

    ma = rst_st();
    mb = rst_st();
    for (int n = 0; n < 400; n++) begin
      cur.stall = ($urandom_range(0, 3) == 0);
      cur.flush = ($urandom_range(0, 9) == 0);
      cur.valid = ($urandom_range(0, 4) != 0);
      cur.pc    = 32'h3000 + 32'($urandom_range(0, 255) * 4);
      cur.instr = $urandom;
      cur.v1    = $urandom;
      cur.v2    = $urandom;
      cur.e32   = $urandom;
      cur.a3    = 5'($urandom_range(0, 31));
      cur.tnew  = 2'($urandom_range(0, 3));
      @(posedge clk);
      ma = step(ma, cur, 1'b0, 1'b0);
      mb = step(mb, cur, 1'b1, 1'b1);
      @(negedge clk);
      chk_both($sformatf("rnd%0d", n), ma, mb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
